// File: rtl/fpu_normalize_round.sv
// Normalize/round/pack stage behind the FPU mantissa adder: one bit of shift per cycle,
// round-to-nearest-even, binary32 result with {overflow, underflow, inexact, zero} flags.
module fpu_normalize_round (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_mant,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        sign_r;
    logic [9:0]  exp_r;
    logic [26:0] mant_r;
    logic        sticky_r;
    logic [31:0] result_r;
    logic [3:0]  flags_r;
    logic        valid_r;

    logic        norm_zero_s, norm_right_s, norm_left_s;
    logic        round_up_s, inexact_s, rnd_bit_s, hidden_s;
    logic [24:0] mant_rnd_s;
    logic [22:0] frac_s;
    logic [9:0]  exp_adj_s;
    logic [31:0] round_result_s;
    logic [3:0]  round_flags_s;

    assign norm_zero_s  = (mant_r == 27'd0) && !sticky_r;
    assign norm_right_s = mant_r[26];
    assign norm_left_s  = !mant_r[25] && (exp_r > 10'd1);

    // Rounding and packing of the normalized mantissa (bit 26 is clear once in ROUND)
    always_comb begin
        rnd_bit_s  = mant_r[0] | sticky_r;
        round_up_s = mant_r[1] & (mant_r[2] | rnd_bit_s);
        inexact_s  = mant_r[1] | rnd_bit_s;
        mant_rnd_s = {1'b0, mant_r[25:2]} + {24'd0, round_up_s};
        if (mant_rnd_s[24]) begin
            hidden_s  = mant_rnd_s[24];
            frac_s    = mant_rnd_s[23:1];
            exp_adj_s = exp_r + 10'd1;
        end else begin
            hidden_s  = mant_rnd_s[23];
            frac_s    = mant_rnd_s[22:0];
            exp_adj_s = exp_r;
        end
        if (exp_adj_s >= 10'd255) begin
            round_result_s = {sign_r, 8'hFF, 23'd0};
            round_flags_s  = 4'b1010;
        end else if (!hidden_s) begin
            round_result_s = {sign_r, 8'd0, frac_s};
            round_flags_s  = {1'b0, inexact_s, inexact_s, 1'b0};
        end else begin
            round_result_s = {sign_r, exp_adj_s[7:0], frac_s};
            round_flags_s  = {2'b00, inexact_s, 1'b0};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nxt_s = NORM;
                else          state_nxt_s = IDLE;
            end
            NORM: begin
                if (norm_zero_s)                      state_nxt_s = DONE;
                else if (norm_right_s || norm_left_s) state_nxt_s = NORM;
                else                                  state_nxt_s = ROUND;
            end
            ROUND: state_nxt_s = DONE;
            DONE: begin
                if (valid_r && out_ready) state_nxt_s = IDLE;
                else                      state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: operand latch, shifting, result capture; valid rises one cycle into DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_r   <= 1'b0;
            exp_r    <= 10'd0;
            mant_r   <= 27'd0;
            sticky_r <= 1'b0;
            result_r <= 32'd0;
            flags_r  <= 4'd0;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sign_r   <= in_sign;
                        exp_r    <= (in_exp == 8'd0) ? 10'd1 : {2'b00, in_exp};
                        mant_r   <= in_mant;
                        sticky_r <= in_sticky;
                    end else begin
                        sticky_r <= sticky_r;
                    end
                end
                NORM: begin
                    if (norm_zero_s) begin
                        result_r <= {sign_r, 31'd0};
                        flags_r  <= 4'b0001;
                    end else if (norm_right_s) begin
                        mant_r   <= {1'b0, mant_r[26:1]};
                        sticky_r <= sticky_r | mant_r[0];
                        exp_r    <= exp_r + 10'd1;
                    end else if (norm_left_s) begin
                        mant_r <= {mant_r[25:0], 1'b0};
                        exp_r  <= exp_r - 10'd1;
                    end else begin
                        mant_r <= mant_r;
                    end
                end
                ROUND: begin
                    result_r <= round_result_s;
                    flags_r  <= round_flags_s;
                end
                DONE: begin
                    if (valid_r && out_ready) valid_r <= 1'b0;
                    else                      valid_r <= 1'b1;
                end
                default: valid_r <= 1'b0;
            endcase
        end
    end

    // Output decode
    always_comb begin
        in_ready   = (state_r == IDLE);
        out_valid  = valid_r;
        out_result = result_r;
        out_flags  = flags_r;
    end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Scoreboard bench for fpu_normalize_round: a driver pushes model results, a monitor
// pops and compares them (value, flags, latency, hold stability) on each output.
module tb_fpu_normalize_round;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [26:0] in_mant = 27'd0;
    logic        in_sticky = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
        int          hold;
    } exp_t;

    exp_t q[$];

    fpu_normalize_round dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: value-level normalize + RNE, latency from the number of shift steps
    task automatic model(input logic s, input logic [7:0] e8, input logic [26:0] m, input logic st,
                         output logic [31:0] res, output logic [3:0] flg, output int lat);
        int e, k, msb;
        longint mv, sig;
        bit sk, g, r, up, inex;
        e  = (e8 == 8'd0) ? 1 : int'(e8);
        mv = longint'(m);
        sk = st;
        if (m == 27'd0 && !st) begin
            res = {s, 31'd0}; flg = 4'b0001; lat = 2;
            return;
        end
        if (m[26]) begin
            sk = sk | m[0];
            mv = mv >> 1;
            e  = e + 1;
            lat = 4;
        end else begin
            msb = -1;
            for (int i = 0; i <= 25; i++) if (mv[i]) msb = i;
            k = (msb < 0) ? e - 1 : (((25 - msb) < (e - 1)) ? 25 - msb : e - 1);
            mv  = mv << k;
            e   = e - k;
            lat = 3 + k;
        end
        sig  = mv >> 2;
        g    = mv[1];
        r    = mv[0] | sk;
        up   = g && (sig[0] || r);
        inex = g || r;
        sig  = sig + (up ? 1 : 0);
        if (sig == (longint'(1) << 24)) begin
            sig = longint'(1) << 23;
            e   = e + 1;
        end
        if (e >= 255) begin
            res = {s, 8'hFF, 23'd0}; flg = 4'b1010;
        end else if (sig < (longint'(1) << 23)) begin
            res = {s, 8'd0, sig[22:0]}; flg = {1'b0, inex, inex, 1'b0};
        end else begin
            res = {s, e[7:0], sig[22:0]}; flg = {2'b00, inex, 1'b0};
        end
    endtask

    task automatic issue(input logic s, input logic [7:0] e, input logic [26:0] m, input logic st,
                         input logic [31:0] res, input logic [3:0] flg, input int lat,
                         input int hold, input bit push);
        int t;
        exp_t x;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
            return;
        end
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_sticky = st;
        @(posedge clk);
        #1;
        x.res = res; x.flg = flg; x.lat = lat; x.acc = cyc; x.hold = hold;
        if (push) q.push_back(x);
        in_valid = 1'b0;
        in_exp   = 8'($urandom);
        in_mant  = 27'($urandom);
    endtask

    task automatic rand_op();
        logic s, st;
        logic [7:0] e;
        logic [26:0] m;
        logic [31:0] res;
        logic [3:0] flg;
        int lat;
        s  = 1'($urandom);
        e  = 8'($urandom);
        st = 1'($urandom);
        case ($urandom_range(0, 4))
            0: m = 27'($urandom);
            1: m = 27'($urandom) >> $urandom_range(0, 26);
            2: m = 27'($urandom) | 27'h4000000;
            3: m = 27'd0;
            default: m = (27'($urandom) & 27'h1FFFFFF) | 27'h2000000;
        endcase
        model(s, e, m, st, res, flg, lat);
        issue(s, e, m, st, res, flg, lat, $urandom_range(0, 2), 1'b1);
    endtask

    // Monitor: pop on first valid cycle, then check the held output until handshake
    initial begin : monitor
        exp_t cur;
        bit seen;
        int hold_left;
        seen = 1'b0;
        hold_left = 0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid actual=%h required=no_output", out_result);
                        cur.res = out_result; cur.flg = out_flags; cur.hold = 0;
                    end else begin
                        cur = q.pop_front();
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        chk("result", out_result, cur.res);
                        chk("flags", {28'd0, out_flags}, {28'd0, cur.flg});
                    end
                    hold_left = cur.hold;
                end else begin
                    chk("hold_result", out_result, cur.res);
                    chk("hold_flags", {28'd0, out_flags}, {28'd0, cur.flg});
                    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
                end
                if (hold_left > 0) begin
                    hold_left--;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                seen = 1'b0;
                out_ready = 1'b0;
            end
        end
    end

    initial begin : driver
        int t;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_flags", {28'd0, out_flags}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;

        issue(1'b0, 8'd127, 27'h2000000, 1'b0, 32'h3F800000, 4'b0000, 3, 0, 1'b1);
        issue(1'b0, 8'd127, 27'h4000000, 1'b0, 32'h40000000, 4'b0000, 4, 1, 1'b1);
        issue(1'b0, 8'd130, 27'h0000004, 1'b0, 32'h35800000, 4'b0000, 26, 0, 1'b1);
        // Busy: a second request held high must not be taken
        in_valid = 1'b1; in_exp = 8'd100; in_mant = 27'h2000000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        issue(1'b0, 8'd127, 27'h2000002, 1'b0, 32'h3F800000, 4'b0010, 3, 0, 1'b1);
        issue(1'b0, 8'd127, 27'h2000006, 1'b0, 32'h3F800002, 4'b0010, 3, 0, 1'b1);
        issue(1'b0, 8'd127, 27'h2000003, 1'b0, 32'h3F800001, 4'b0010, 3, 0, 1'b1);
        issue(1'b0, 8'd254, 27'h4000000, 1'b0, 32'h7F800000, 4'b1010, 4, 0, 1'b1);
        issue(1'b1, 8'd127, 27'h0000000, 1'b0, 32'h80000000, 4'b0001, 2, 0, 1'b1);
        issue(1'b0, 8'd1,   27'h0000006, 1'b0, 32'h00000002, 4'b0110, 3, 5, 1'b1);

        // Reset mid-NORM aborts the operation
        issue(1'b0, 8'd130, 27'h0000004, 1'b0, 32'h0, 4'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_output", {31'd0, out_valid}, 32'd0);
        issue(1'b0, 8'd127, 27'h2000000, 1'b0, 32'h3F800000, 4'b0000, 3, 0, 1'b1);

        for (int n = 0; n < 200; n++) rand_op();

        t = 0;
        while ((q.size() != 0 || out_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || out_valid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_normalize_round.md
# fpu_normalize_round

Sequential normalization, rounding and packing stage placed directly downstream of the FPU mantissa adder. It accepts one raw sum (sign, larger biased exponent, widened mantissa with guard/round/sticky), shifts it one bit per cycle until normalized, and rounds to nearest-even. It then packs an IEEE-754 single-precision result with status flags for the multicycle ARM datapath. Valid/ready handshakes on both sides; one operation in flight at a time.

## Interface
- No parameters (fixed binary32 format).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  raw sum present
- in_ready  out  1  high only in IDLE
- in_sign  in  1  sign of the sum
- in_exp  in  8  biased exponent of the larger operand (0 is treated as 1)
- in_mant  in  27  [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] round
- in_sticky  in  1  OR of bits shifted out during alignment
- out_valid  out  1  result held until accepted
- out_ready  in  1  consumer accepts
- out_result  out  32  {sign, exp[7:0], frac[22:0]}
- out_flags  out  4  {overflow, underflow, inexact, zero}

## Operation
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, latch the sign, exponent E (10-bit signed, max(in_exp,1)), mantissa M and sticky S. Then go to NORM.
- NORM evaluates one action per cycle, in priority order:
  - M==0 and S==0: result {sign,31'b0}, flags zero=1, go to DONE.
  - M[26]=1: M>>=1, S|=M[0], E+=1. Stay in NORM.
  - M[25]=0 and E>1: M<<=1 (zero fill), E-=1. Stay in NORM.
  - Otherwise: go to ROUND.
- ROUND uses L=M[2], G=M[1], R=M[0]|S. Round up (add 1 at bit 2) if G & (L|R). inexact=G|R.
  - If rounding carries into bit 26: M>>=1, E+=1, in the same cycle.
  - E>=255 after rounding: result {sign,8'hFF,23'b0}, overflow=1, inexact=1.
  - Else if M[25]=0: denormal, exponent field 0, underflow=inexact.
  - Else: exponent field E[7:0], fraction M[24:2].
  - Go to DONE.
- DONE: out_valid=1, with out_result/out_flags stable. On out_ready, go to IDLE. A new input can be accepted no earlier than the cycle after the handshake.
- Left shifting stops at E==1. Maximum 25 left shifts, or 1 right shift.

## Timing
- Reset (async): state IDLE, out_valid=0, out_result=0, out_flags=0, in_ready=1.
- Accept happens at edge N. Latency to out_valid:
  - Already-normalized input: N+3 (NORM, ROUND, DONE).
  - Carry input: N+4.
  - k left shifts: N+3+k.
  - Zero: N+2.
- out_valid, out_result and out_flags are registered. in_ready is a decode of the state.
- out_ready low in DONE: hold indefinitely, with no output change.
- in_valid while busy: ignored (not latched). The upstream stage must hold its data.
- Reset mid-operation aborts the operation: no out_valid is produced, and the block is ready again after reset deasserts.

## Test plan
- Normalized input: in_exp=127, in_mant=27'h2000000, sticky=0 -> out_result=0x3F800000, flags=0, out_valid at accept+3.
- Carry input: in_exp=127, in_mant=27'h4000000 -> 0x40000000, out_valid at accept+4.
- Cancellation: in_exp=130, in_mant=27'h0000004 -> 23 left shifts, 0x35800000, out_valid at accept+26. A second in_valid during the operation is not accepted.
- Round-to-nearest-even:
  - in_exp=127, mant=27'h2000002 -> 0x3F800000, inexact=1.
  - mant=27'h2000006 -> 0x3F800002, inexact=1.
  - mant=27'h2000003 -> 0x3F800001.
- Overflow, zero and underflow:
  - in_exp=254, mant=27'h4000000 -> 0x7F800000, overflow=1, inexact=1.
  - mant=0, sticky=0, sign=1 -> 0x80000000, zero=1, out_valid at accept+2.
  - in_exp=1, mant=27'h0000006 -> 0x00000002 (denormal), inexact=1, underflow=1.
- Handshake and reset:
  - out_ready held low 5 cycles in DONE -> result stable, in_ready=0.
  - Assert reset during NORM -> out_valid stays 0, and the next operation completes normally.
